rc_sym_upsampler: RTL and testbench

//  Symbol-to-sample front end for the raised-cosine pulse-shaping FIR (rcosine, 8-tap-pair, din 8b).

---
 rtl/rc_sym_upsampler.sv | 108 ++++++++++
 tb/tb_rc_sym_upsampler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc_sym_upsampler.sv
// Symbol-to-sample upsampler feeding the raised-cosine FIR: small symbol FIFO plus phase counter,
// zero-stuffing by default; define RCUPS_ZOH_EN for zero-order hold on the non-symbol phases.
module rc_sym_upsampler #(
  parameter int               DSIZE    = 8,
  parameter int               OSR      = 4,
  parameter int               FIFO_AW  = 2,
  parameter logic [DSIZE-1:0] ZERO_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DSIZE-1:0]   sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic [DSIZE-1:0]   dout,
  output logic               sym_strobe,
  output logic               underflow,
  input  logic               clr_status,
  output logic [FIFO_AW:0]   fifo_cnt
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam int                 PH_W     = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PH_W-1:0]    PH_LAST  = PH_W'(OSR - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  logic [DSIZE-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   cnt;
  logic [PH_W-1:0]    ph;
  logic               push;
  logic               pop;
  logic               empty;
  logic               ph0;

  // Ready depends only on the registered count, so a pop never combinationally frees a slot.
  assign sym_ready = (cnt != CNT_FULL);
  assign empty     = (cnt == '0);
  assign ph0       = (ph == '0);
  assign push      = sym_valid & sym_ready;
  assign pop       = run & ph0 & ~empty;
  assign fifo_cnt  = cnt;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= sym_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ph        <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (!run || ph == PH_LAST) begin
        ph <= '0;
      end else begin
        ph <= ph + 1'b1;
      end
      // A new underflow wins over a clear in the same cycle.
      if (run && ph0 && empty) begin
        underflow <= 1'b1;
      end else if (clr_status) begin
        underflow <= 1'b0;
      end
    end
  end

  // Output register stage: one sample per clk into the FIR.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= ZERO_VAL;
      sym_strobe <= 1'b0;
    end else if (!run) begin
      dout       <= ZERO_VAL;
      sym_strobe <= 1'b0;
    end else if (pop) begin
      dout       <= mem[rd_ptr];
      sym_strobe <= 1'b1;
    end else if (ph0) begin
      dout       <= ZERO_VAL;
      sym_strobe <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
`ifdef RCUPS_ZOH_EN
      dout       <= dout;
`else
      dout       <= ZERO_VAL;
`endif
    end
  end

endmodule

// File: tb/tb_rc_sym_upsampler.sv
// Self-checking bench for rc_sym_upsampler: symbol scoreboard with a cycle model of phase,
// occupancy and status, plus directed reset/stuffing/full/underflow/mid-stream-reset sequences.
module tb_rc_sym_upsampler;

  localparam int DSIZE = 8;
  localparam int OSR   = 4;
  localparam int DEPTH = 4;

  localparam logic [7:0] SEQ_D [12] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00,
                                        8'h30, 8'h00, 8'h00, 8'h00};
  localparam logic       SEQ_S [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                        1'b1, 1'b0, 1'b0, 1'b0};

  logic             clk;
  logic             rst;
  logic             run;
  logic [DSIZE-1:0] sym_in;
  logic             sym_valid;
  logic             sym_ready;
  logic [DSIZE-1:0] dout;
  logic             sym_strobe;
  logic             underflow;
  logic             clr_status;
  logic [2:0]       fifo_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rc_sym_upsampler #(
    .DSIZE   (DSIZE),
    .OSR     (OSR),
    .FIFO_AW (2),
    .ZERO_VAL(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .dout      (dout),
    .sym_strobe(sym_strobe),
    .underflow (underflow),
    .clr_status(clr_status),
    .fifo_cnt  (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted symbols are queued at the edge they are pushed, popped when they are due out.
  logic [7:0] q[$];
  int         ph_m;
  logic [7:0] exp_dout;
  logic       exp_strobe;
  logic       exp_uf;
  bit         armed = 0;

  always @(posedge clk) begin
    logic       r, rn, v, c;
    logic [7:0] d;
    bit         pop_e, uf_set, push_e;
    r  = rst;
    rn = run;
    v  = sym_valid;
    c  = clr_status;
    d  = sym_in;
    if (r) begin
      armed      = 1;
      q.delete();
      ph_m       = 0;
      exp_dout   = 8'h00;
      exp_strobe = 1'b0;
      exp_uf     = 1'b0;
    end else if (armed) begin
      pop_e  = rn && (ph_m == 0) && (q.size() > 0);
      uf_set = rn && (ph_m == 0) && (q.size() == 0);
      push_e = v && (q.size() != DEPTH);
      exp_strobe = 1'b0;
      if (!rn) begin
        exp_dout = 8'h00;
      end else if (pop_e) begin
        exp_dout   = q.pop_front();
        exp_strobe = 1'b1;
      end else if (ph_m == 0) begin
        exp_dout = 8'h00;
      end else begin
`ifndef RCUPS_ZOH_EN
        exp_dout = 8'h00;
`endif
      end
      if (uf_set)  exp_uf = 1'b1;
      else if (c)  exp_uf = 1'b0;
      ph_m = rn ? (ph_m + 1) % OSR : 0;
      if (push_e) q.push_back(d);
    end
    #1;
    if (armed) begin
      chk("mon_dout",   dout,       exp_dout);
      chk("mon_strobe", sym_strobe, exp_strobe);
      chk("mon_uf",     underflow,  exp_uf);
      chk("mon_cnt",    fifo_cnt,   q.size());
      chk("mon_ready",  sym_ready,  q.size() != DEPTH);
    end
  end

  initial begin
    // Reset with garbage on every input
    rst = 1'b1; run = 1'b1; sym_valid = 1'b1; sym_in = 8'hAA; clr_status = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0; sym_valid = 1'b0; clr_status = 1'b0;
    chk("rst_dout",   dout,       8'h00);
    chk("rst_strobe", sym_strobe, 1'b0);
    chk("rst_cnt",    fifo_cnt,   3'd0);
    chk("rst_ready",  sym_ready,  1'b1);
    chk("rst_uf",     underflow,  1'b0);

    // Zero stuffing
    sym_valid = 1'b1;
    sym_in = 8'h10; tick();
    sym_in = 8'h20; tick();
    sym_in = 8'h30; tick();
    sym_valid = 1'b0;
    chk("stuff_cnt", fifo_cnt, 3'd3);
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
`ifndef RCUPS_ZOH_EN
      chk("stuff_dout", dout, SEQ_D[i]);
`endif
      chk("stuff_strobe", sym_strobe, SEQ_S[i]);
    end
    run = 1'b0;
    chk("stuff_uf", underflow, 1'b0);

    // Full FIFO
    sym_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sym_in = 8'hA1 + 8'(i);
      tick();
    end
    sym_valid = 1'b0;
    chk("full_cnt",   fifo_cnt,  3'd4);
    chk("full_ready", sym_ready, 1'b0);
    run = 1'b1;
    tick();
    chk("full_first", dout,      8'hA1);
    chk("full_cnt3",  fifo_cnt,  3'd3);
    chk("full_rdy1",  sym_ready, 1'b1);
    repeat (15) tick();
    run = 1'b0;
    chk("full_drain", fifo_cnt,  3'd0);
    chk("full_nouf",  underflow, 1'b0);

    // Underflow: sticky, set beats clear, clear alone works
    run = 1'b1;
    tick();
    chk("uf_set",    underflow,  1'b1);
    chk("uf_dout",   dout,       8'h00);
    chk("uf_strobe", sym_strobe, 1'b0);
    repeat (3) tick();
    chk("uf_sticky", underflow, 1'b1);
    clr_status = 1'b1;
    tick();
    chk("uf_setwins", underflow, 1'b1);
    run = 1'b0;
    tick();
    chk("uf_clr", underflow, 1'b0);
    clr_status = 1'b0;

    // Reset mid-stream at ph=2
    sym_valid = 1'b1;
    sym_in = 8'hC1; tick();
    sym_in = 8'hC2; tick();
    sym_in = 8'hC3; tick();
    sym_valid = 1'b0;
    run = 1'b1;
    tick();
    chk("mid_pop", dout, 8'hC1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_cnt",   fifo_cnt,  3'd0);
    chk("mid_ready", sym_ready, 1'b1);
    chk("mid_dout",  dout,      8'h00);
    repeat (8) begin
      tick();
      chk("mid_strobe", sym_strobe, 1'b0);
      chk("mid_zero",   dout,       8'h00);
    end
    run = 1'b0; clr_status = 1'b1;
    tick();
    clr_status = 1'b0;

`ifdef RCUPS_ZOH_EN
    sym_valid = 1'b1;
    sym_in = 8'h7F; tick();
    sym_in = 8'h01; tick();
    sym_valid = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("zoh_dout", dout, (i < 4) ? 8'h7F : 8'h01);
    end
    run = 1'b0;
    tick();
`endif

    // Random traffic, checked by the scoreboard
    repeat (400) begin
      rst        = ($urandom_range(0, 99) == 0);
      run        = ($urandom_range(0, 7) != 0);
      sym_valid  = 1'($urandom_range(0, 1));
      sym_in     = 8'($urandom);
      clr_status = ($urandom_range(0, 19) == 0);
      tick();
    end
    rst = 1'b0; run = 1'b0; sym_valid = 1'b0; clr_status = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
